// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci round blocks (forward and inverse).
// Holds the FSM state encoding, the default widths and the recurrence seed values.
package fib_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_MAX_N = 255;

  // Recurrence seeds: F(0) and F(1)
  localparam int F0 = 0;
  localparam int F1 = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/fib_step.sv
// One Fibonacci round, purely combinational: (F(i), F(i+1)) -> (F(i+1), F(i+2)) mod 2^WIDTH.
// The forward blocks use this same module, so both directions share one recurrence.
module fib_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] fi,
  input  logic [WIDTH-1:0] fn,
  output logic [WIDTH-1:0] fi_next,
  output logic [WIDTH-1:0] fn_next
);

  assign fi_next = fn;
  assign fn_next = fi + fn;

endmodule

// File: rtl/fib_index.sv
// Finds the smallest n with F(n) mod 2^WIDTH == v, one round per cycle; match at k -> k+1 cycles.
// Single search in flight: in_ready only in IDLE; the result is held in DONE until out_ready.
module fib_index
  import fib_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int MAX_N = DEFAULT_MAX_N
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] v,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             found,
  output logic [WIDTH-1:0] n_out
);

  localparam logic [WIDTH-1:0] LAST_IDX = WIDTH'(MAX_N);
  localparam logic [WIDTH-1:0] INIT_FI  = WIDTH'(F0);
  localparam logic [WIDTH-1:0] INIT_FN  = WIDTH'(F1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] i;
  logic [WIDTH-1:0] fi;
  logic [WIDTH-1:0] fn;
  logic [WIDTH-1:0] fi_step;
  logic [WIDTH-1:0] fn_step;
  logic             hit;
  logic             at_limit;
  logic             load;
  logic             advance;
  logic             finish;

  fib_step #(.WIDTH(WIDTH)) u_step (
    .fi      (fi),
    .fn      (fn),
    .fi_next (fi_step),
    .fn_next (fn_step)
  );

  // Match is tested before the limit, so a hit at i == MAX_N still reports found.
  assign hit      = (fi == target);
  assign at_limit = (i == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    load      = 1'b0;
    advance   = 1'b0;
    finish    = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load      = 1'b1;
          state_nxt = SEARCH;
        end
      end
      SEARCH: begin
        if (hit || at_limit) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end else begin
          advance = 1'b1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target <= '0;
      i      <= '0;
      fi     <= INIT_FI;
      fn     <= INIT_FN;
      found  <= 1'b0;
      n_out  <= '0;
    end else begin
      if (load) begin
        target <= v;
        i      <= '0;
        fi     <= INIT_FI;
        fn     <= INIT_FN;
      end else if (advance) begin
        i  <= i + WIDTH'(1);
        fi <= fi_step;
        fn <= fn_step;
      end
      if (finish) begin
        found <= hit;
        n_out <= hit ? i : LAST_IDX;
      end
    end
  end

endmodule

// File: tb/tb_fib_index.sv
// Scoreboard bench for fib_index: driver pushes reference results, a monitor pops and compares.
// Reference is a precomputed table of F(k) mod 256 searched for the first occurrence.
module tb_fib_index;

  localparam int W    = 8;
  localparam int MAXN = 255;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] v;
  logic         out_valid;
  logic         out_ready;
  logic         found;
  logic [W-1:0] n_out;

  always #5 clk = ~clk;

  fib_index #(.WIDTH(W), .MAX_N(MAXN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .v         (v),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .found     (found),
    .n_out     (n_out)
  );

  typedef struct {
    logic         f;
    logic [W-1:0] n;
    int           lat;
    int           acc;
  } exp_t;

  exp_t         sbq[$];
  exp_t         cur;
  int           tests = 0;
  int           fails = 0;
  int           cyc = 0;
  int           rdy_mode = 1;
  bit           seen;
  bit           prev_hs;
  logic         hold_f;
  logic [W-1:0] hold_n;
  int           fibtab[MAXN+1];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input int val);
    exp_t e;
    e.f   = 1'b0;
    e.n   = W'(MAXN);
    e.lat = MAXN + 1;
    e.acc = 0;
    for (int k = MAXN; k >= 0; k--) begin
      if (fibtab[k] == val) begin
        e.f   = 1'b1;
        e.n   = W'(k);
        e.lat = k + 1;
      end
    end
    return e;
  endfunction

  // Called just after a falling edge; returns just after the falling edge following the accept.
  task automatic send(input logic [W-1:0] val);
    exp_t e;
    int   t;
    t        = 0;
    in_valid = 1'b1;
    v        = val;
    while (!in_ready && t < 800) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
    v        = W'($urandom);
    e        = model(int'(val));
    e.acc    = cyc;
    sbq.push_back(e);
    chk("in_ready_low_in_search", in_ready, 0);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sbq.size() != 0 || out_valid) && t < 1500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1500) chk("drain_timeout", 0, 1);
  endtask

  task automatic wait_out_valid();
    int t;
    t = 0;
    while (!out_valid && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid) chk("out_valid_timeout", 0, 1);
  endtask

  // Monitor: drives out_ready per mode, checks each result once and its stability while held.
  initial begin
    seen      = 1'b0;
    prev_hs   = 1'b0;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        seen    = 1'b0;
        prev_hs = 1'b0;
        continue;
      end
      if (prev_hs) begin
        chk("idle_after_handshake", {out_valid, in_ready}, 2'b01);
        prev_hs = 1'b0;
      end
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (out_valid) begin
        chk("in_ready_low_in_done", in_ready, 0);
        if (!seen) begin
          if (sbq.size() == 0) begin
            chk("unexpected_result", sbq.size(), 1);
          end else begin
            cur = sbq.pop_front();
            chk("found", found, cur.f);
            chk("n_out", n_out, cur.n);
            chk("latency", cyc - cur.acc, cur.lat);
          end
          seen   = 1'b1;
          hold_f = found;
          hold_n = n_out;
        end else begin
          chk("found_stable", found, hold_f);
          chk("n_out_stable", n_out, hold_n);
        end
        if (out_ready) begin
          seen    = 1'b0;
          prev_hs = 1'b1;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    fibtab[0] = 0;
    fibtab[1] = 1;
    for (int j = 2; j <= MAXN; j++) fibtab[j] = (fibtab[j-1] + fibtab[j-2]) % 256;

    rst      = 1'b1;
    in_valid = 1'b0;
    v        = '0;
    rdy_mode = 1;
    repeat (2) @(negedge clk);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_found", found, 0);
    chk("reset_n_out", n_out, 0);
    rst = 1'b0;
    @(negedge clk);

    send(8'd13);
    drain();
    send(8'd0);
    send(8'd1);
    drain();
    send(8'd121);
    send(8'd98);
    drain();
    send(8'd4);
    drain();

    // Backpressure: result must hold for 20 cycles with out_ready low.
    rdy_mode = 0;
    send(8'd144);
    wait_out_valid();
    repeat (20) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
    end
    rdy_mode = 1;
    drain();

    // Reset while holding a result: out_valid must drop with no clock edge.
    rdy_mode = 0;
    send(8'd21);
    wait_out_valid();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_done_out_valid", out_valid, 0);
    chk("rst_done_in_ready", in_ready, 1);
    sbq.delete();
    @(negedge clk);
    @(negedge clk);
    rst      = 1'b0;
    rdy_mode = 1;
    @(negedge clk);

    // Reset mid-search, then a clean search must still work.
    send(8'd4);
    repeat (48) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_search_out_valid", out_valid, 0);
    chk("rst_search_in_ready", in_ready, 1);
    sbq.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    send(8'd8);
    drain();

    rdy_mode = 2;
    repeat (40) begin
      if ($urandom_range(0, 1) == 1) k = fibtab[$urandom_range(0, MAXN)];
      else k = int'($urandom_range(0, 255));
      send(W'(k));
      if ($urandom_range(0, 3) == 0) drain();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
